wave_osc: RTL and testbench

WAVE_OSC -- requirements
Module: wave_osc

---
 rtl/wave_osc_if.sv | 25 ++
 rtl/wave_osc.sv | 113 +++++++++++
 tb/tb_wave_osc.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wave_osc_if.sv
// rtl/wave_osc_if.sv - control and sample-stream bundle for the wave oscillator
interface wave_osc_if #(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24
);
    logic                            enable_i;
    logic                            sync_i;
    logic [1:0]                      mode_i;
    logic [phase_width_p-1:0]        phase_inc_i;
    logic [phase_width_p-1:0]        duty_i;
    logic                            ready_i;
    logic                            valid_o;
    logic signed [width_p-1:0]       data_o;
    logic                            wrap_o;

    modport master (
        output enable_i, sync_i, mode_i, phase_inc_i, duty_i, ready_i,
        input  valid_o, data_o, wrap_o
    );

    modport slave (
        input  enable_i, sync_i, mode_i, phase_inc_i, duty_i, ready_i,
        output valid_o, data_o, wrap_o
    );
endinterface

// File: rtl/wave_osc.sv
// rtl/wave_osc.sv - phase-accumulator oscillator with saw/triangle/square/silence output
module wave_osc #(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    wave_osc_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_SAW = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SQR = 2'd2,
        MODE_SIL = 2'd3
    } mode_e;

    logic [phase_width_p-1:0]   r_phase;
    logic [phase_width_p-1:0]   w_phase_nxt;
    logic signed [width_p-1:0]  r_data;
    logic signed [width_p-1:0]  w_data_nxt;
    logic                       r_valid;
    logic                       w_valid_nxt;
    logic                       r_wrap;
    logic                       w_wrap_nxt;
    mode_e                      r_mode_act;
    mode_e                      w_mode_act_nxt;
    mode_e                      r_mode_pend;

    logic [phase_width_p:0]     w_sum;
    logic                       w_carry;
    logic                       w_load;
    logic                       w_fire;
    mode_e                      w_wave_mode;
    logic [phase_width_p-1:0]   w_wave_phase;
    logic [width_p-1:0]         w_u;
    logic [width_p-1:0]         w_t;
    logic signed [width_p-1:0]  w_wave;

    assign w_sum   = {1'b0, r_phase} + {1'b0, bus.phase_inc_i};
    assign w_carry = w_sum[phase_width_p];
    assign w_load  = !r_valid || bus.ready_i;
    assign w_fire  = w_load && bus.enable_i;

    // A sync on a firing cycle restarts the waveform at phase 0 in the pending mode.
    assign w_wave_mode  = bus.sync_i ? r_mode_pend : r_mode_act;
    assign w_wave_phase = bus.sync_i ? '0 : r_phase;
    assign w_u = w_wave_phase[phase_width_p-1 -: width_p];
    assign w_t = w_u[width_p-1] ? {~w_u[width_p-2:0], 1'b0} : {w_u[width_p-2:0], 1'b0};

    always_comb begin
        w_wave = '0;
        case (w_wave_mode)
            MODE_SAW: w_wave = {~w_u[width_p-1], w_u[width_p-2:0]};
            MODE_TRI: w_wave = {~w_t[width_p-1], w_t[width_p-2:0]};
            MODE_SQR: w_wave = (w_wave_phase < bus.duty_i) ?
                               {1'b0, {(width_p-1){1'b1}}} :
                               {1'b1, {(width_p-2){1'b0}}, 1'b1};
            default:  w_wave = '0;
        endcase
    end

    always_comb begin
        w_phase_nxt    = r_phase;
        w_data_nxt     = r_data;
        w_valid_nxt    = r_valid;
        w_wrap_nxt     = 1'b0;
        w_mode_act_nxt = r_mode_act;
        if (w_fire) begin
            w_data_nxt  = w_wave;
            w_valid_nxt = 1'b1;
            if (bus.sync_i) begin
                w_phase_nxt    = bus.phase_inc_i;
                w_mode_act_nxt = r_mode_pend;
            end else begin
                w_phase_nxt = w_sum[phase_width_p-1:0];
                if (w_carry) begin
                    w_wrap_nxt     = 1'b1;
                    w_mode_act_nxt = r_mode_pend;
                end
            end
        end else begin
            if (w_load) begin
                w_valid_nxt = 1'b0;
            end
            if (bus.sync_i) begin
                w_phase_nxt    = '0;
                w_mode_act_nxt = r_mode_pend;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_phase     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_mode_act  <= MODE_SIL;
            r_mode_pend <= MODE_SIL;
        end else begin
            r_phase     <= w_phase_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
            r_mode_act  <= w_mode_act_nxt;
            r_mode_pend <= mode_e'(bus.mode_i);
        end
    end

    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
    assign bus.wrap_o  = r_wrap;
endmodule

// File: tb/tb_wave_osc.sv
// tb/tb_wave_osc.sv - directed bench with a cycle model for wave_osc
module tb_wave_osc;
    localparam int W  = 12;
    localparam int PW = 24;
    localparam longint PMOD = 64'd1 << PW;
    localparam int HALF = 1 << (W - 1);
    localparam int MAXV = HALF - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    wave_osc_if #(.width_p(W), .phase_width_p(PW)) vif ();

    wave_osc #(.width_p(W), .phase_width_p(PW)) dut (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus     (vif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value straight from the waveform definitions, as integers.
    function automatic int wave(input int md, input longint ph);
        int u;
        u = int'(ph >> (PW - W));
        case (md)
            0: return u - HALF;
            1: return (u < HALF) ? 2 * u - HALF : 2 * ((2 * HALF - 1) - u) - HALF;
            2: return (ph < longint'(vif.duty_i)) ? MAXV : -MAXV;
            default: return 0;
        endcase
    endfunction

    longint m_phase = 0;
    int m_act = 3;
    int m_pend = 3;
    bit m_valid = 1'b0;
    int m_data = 0;
    bit m_wrap = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        longint sum;
        bit ld;
        bit nw;
        if (!rst_n) begin
            m_phase = 0; m_act = 3; m_pend = 3;
            m_valid = 1'b0; m_data = 0; m_wrap = 1'b0;
        end else begin
            ld = !m_valid || vif.ready_i;
            nw = 1'b0;
            if (ld && vif.enable_i) begin
                if (vif.sync_i) begin
                    m_data  = wave(m_pend, 0);
                    m_phase = longint'(vif.phase_inc_i);
                    m_act   = m_pend;
                end else begin
                    m_data = wave(m_act, m_phase);
                    sum = m_phase + longint'(vif.phase_inc_i);
                    if (sum >= PMOD) begin
                        nw = 1'b1;
                        m_act = m_pend;
                    end
                    m_phase = sum % PMOD;
                end
                m_valid = 1'b1;
            end else begin
                if (ld) m_valid = 1'b0;
                if (vif.sync_i) begin
                    m_phase = 0;
                    m_act = m_pend;
                end
            end
            m_wrap = nw;
            m_pend = int'(vif.mode_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_valid", int'(vif.valid_o), int'(m_valid));
            check("cyc_wrap", int'(vif.wrap_o), int'(m_wrap));
            check("cyc_data", int'(vif.data_o), m_data);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_wrap();
        for (int i = 0; i < 20; i++) begin
            if (vif.wrap_o) break;
            step(1);
        end
        check("wrap_seen", int'(vif.wrap_o), 1);
    endtask

    int sq_pat [8] = '{MAXV, MAXV, MAXV, MAXV, -MAXV, -MAXV, -MAXV, -MAXV};

    initial begin
        vif.enable_i = 1'b0; vif.sync_i = 1'b0; vif.mode_i = 2'd0;
        vif.phase_inc_i = 24'd4096; vif.duty_i = '0; vif.ready_i = 1'b1;
        #22;
        check("rst_valid", int'(vif.valid_o), 0);
        check("rst_data", int'(vif.data_o), 0);
        check("rst_wrap", int'(vif.wrap_o), 0);
        step(1);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step(2);

        vif.enable_i = 1'b1;
        step(1);
        check("sil_valid", int'(vif.valid_o), 1);
        check("sil_data", int'(vif.data_o), 0);
        step(2);
        check("sil_data2", int'(vif.data_o), 0);

        vif.sync_i = 1'b1;
        step(1);
        vif.sync_i = 1'b0;
        check("saw0", int'(vif.data_o), -2048);
        step(1);
        check("saw1", int'(vif.data_o), -2047);
        step(1);
        check("saw2", int'(vif.data_o), -2046);

        vif.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_data", int'(vif.data_o), -2046);
            check("stall_valid", int'(vif.valid_o), 1);
        end
        vif.ready_i = 1'b1;
        step(1);
        check("after_stall", int'(vif.data_o), -2045);

        vif.mode_i = 2'd1;
        vif.phase_inc_i = 24'd1 << 22;
        step(1);
        check("saw_u4", int'(vif.data_o), -2044);
        wait_wrap();
        check("saw_at_wrap", int'(vif.data_o), 1028);
        step(1);
        check("tri_first", int'(vif.data_o), -2040);
        check("tri_nowrap", int'(vif.wrap_o), 0);

        vif.mode_i = 2'd2;
        vif.phase_inc_i = 24'd1 << 21;
        vif.duty_i = 24'd1 << 23;
        step(1);
        vif.sync_i = 1'b1;
        step(1);
        vif.sync_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("sq_data", int'(vif.data_o), sq_pat[k % 8]);
            check("sq_wrap", int'(vif.wrap_o), (k % 8 == 7) ? 1 : 0);
            step(1);
        end

        vif.duty_i = '0;
        step(2);
        check("duty0", int'(vif.data_o), -MAXV);

        vif.enable_i = 1'b0;
        step(1);
        check("en0_valid", int'(vif.valid_o), 0);
        vif.enable_i = 1'b1;
        vif.phase_inc_i = '0;
        step(3);
        check("inc0_data", int'(vif.data_o), -MAXV);
        check("inc0_wrap", int'(vif.wrap_o), 0);

        vif.mode_i = 2'd0;
        vif.phase_inc_i = 24'd4096;
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(vif.valid_o), 0);
        check("async_data", int'(vif.data_o), 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_valid", int'(vif.valid_o), 1);
        check("post_rst_data", int'(vif.data_o), 0);
        step(2);
        check("post_rst_data2", int'(vif.data_o), 0);

        step(1);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
